fifo_drain: RTL and testbench



---
 rtl/fifo_drain.sv | 110 +++++++++++
 tb/tb_fifo_drain.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: skewed serial-to-parallel collector for the array output edge.
// Drops SKIP leading samples, assembles DEPTH samples, hands off via valid/ready.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          arm one collection (IDLE only)
//   en, d          sample strobe and signed serial sample
//   q              assembled vector, q[0] = first kept sample
//   q_valid        q complete and stable
//   q_ready        consumer accepts q
//   busy           collecting (SKIP or FILL)
//   overflow       sticky: sample dropped while FULL
module fifo_drain #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8,
  parameter int SKIP  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   en,
  input  logic signed [BITS-1:0] d,
  output logic signed [BITS-1:0] q [DEPTH-1:0],
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic                   busy,
  output logic                   overflow
);

  localparam int MAXC = (SKIP > DEPTH) ? SKIP : DEPTH;
  localparam int CW   = $clog2(MAXC) + 1;

  // With SKIP=0 the skip phase is never entered; the compare value is unused.
  localparam logic [CW-1:0] SKIP_LAST =
    CW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [CW-1:0] FILL_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_FILL,
    S_FULL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      q_valid  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < DEPTH; i++)
              q[i] <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= (SKIP > 0) ? S_SKIP : S_FILL;
          end
        end
        S_SKIP: begin
          if (en) begin
            if (cnt == SKIP_LAST) begin
              cnt   <= '0;
              state <= S_FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (en) begin
            // Shift toward q[0] so the first kept sample ends in q[0].
            for (int i = 0; i < DEPTH - 1; i++)
              q[i] <= q[i+1];
            q[DEPTH-1] <= d;
            if (cnt == FILL_LAST) begin
              cnt     <= '0;
              state   <= S_FULL;
              q_valid <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (en)
            overflow <= 1'b1;
          if (q_ready) begin
            state   <= S_IDLE;
            q_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed and random stimulus on two fifo_drain instances
// (SKIP=3 and SKIP=0, DEPTH=4) against a queue-based reference model.
module tb_fifo_drain;

  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;
  logic q_ready = 1'b0;
  logic signed [7:0] d = '0;

  logic signed [7:0] qa [3:0];
  logic signed [7:0] qb [3:0];
  logic va, vb, ba, bb, oa, ob;

  fifo_drain #(.DEPTH(4), .BITS(8), .SKIP(3)) ua (
    .clk(clk), .rst(rst), .start(start), .en(en), .d(d),
    .q(qa), .q_valid(va), .q_ready(q_ready),
    .busy(ba), .overflow(oa)
  );

  fifo_drain #(.DEPTH(4), .BITS(8), .SKIP(0)) ub (
    .clk(clk), .rst(rst), .start(start), .en(en), .d(d),
    .q(qb), .q_valid(vb), .q_ready(q_ready),
    .busy(bb), .overflow(ob)
  );

  int total = 0;
  int bad = 0;
  bit armed = 0;

  // Reference: collecting flag, skipped count, queue of kept samples.
  bit m_act [2];
  bit m_full [2];
  bit m_ovf [2];
  int m_skp [2];
  logic signed [7:0] m_kept [2][$];

  function automatic int skip_of(int u);
    return (u == 0) ? 3 : 0;
  endfunction

  // Kept samples occupy the top of q, zeros below them.
  function automatic logic signed [7:0] exp_q(int u, int i);
    int n;
    n = m_kept[u].size();
    if (i >= D - n)
      return m_kept[u][i-(D-n)];
    return '0;
  endfunction

  task automatic model();
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_act[u] = 0;
        m_full[u] = 0;
        m_ovf[u] = 0;
        m_skp[u] = 0;
        m_kept[u].delete();
        armed = 1;
      end else if (m_full[u]) begin
        if (en) m_ovf[u] = 1;
        if (q_ready) m_full[u] = 0;
      end else if (m_act[u]) begin
        if (en) begin
          if (m_skp[u] < skip_of(u)) begin
            m_skp[u]++;
          end else begin
            m_kept[u].push_back(d);
            if (m_kept[u].size() == D) begin
              m_full[u] = 1;
              m_act[u] = 0;
            end
          end
        end
      end else if (start) begin
        m_act[u] = 1;
        m_skp[u] = 0;
        m_ovf[u] = 0;
        m_kept[u].delete();
      end
    end
  endtask

  task automatic chk(string name, logic signed [31:0] act,
                     logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int u, logic signed [7:0] qv [3:0],
                     logic v, logic b, logic o);
    chk($sformatf("u%0d q_valid", u), {31'd0, v}, {31'd0, m_full[u]});
    chk($sformatf("u%0d busy", u), {31'd0, b}, {31'd0, m_act[u]});
    chk($sformatf("u%0d overflow", u), {31'd0, o}, {31'd0, m_ovf[u]});
    for (int i = 0; i < D; i++)
      chk($sformatf("u%0d q[%0d]", u, i), 32'(qv[i]), 32'(exp_q(u, i)));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, qa, va, ba, oa);
      cmp(1, qb, vb, bb, ob);
    end
  end

  task automatic step(bit r, bit s, bit e, int dv, bit rd);
    rst = r;
    start = s;
    en = e;
    d = 8'(dv);
    q_ready = rd;
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic chk_qa(string name, int a0, int a1, int a2, int a3);
    chk({name, " q0"}, 32'(qa[0]), a0);
    chk({name, " q1"}, 32'(qa[1]), a1);
    chk({name, " q2"}, 32'(qa[2]), a2);
    chk({name, " q3"}, 32'(qa[3]), a3);
  endtask

  int s1 [7] = '{0, 0, 0, 5, -3, 127, -128};

  initial begin
    step(1, 0, 0, 0, 0);
    chk("rst valid", {31'd0, va}, 0);
    chk("rst busy", {31'd0, ba}, 0);
    chk("rst ovf", {31'd0, oa}, 0);
    chk_qa("rst", 0, 0, 0, 0);

    // Contiguous stream.
    step(0, 1, 0, 0, 0);
    chk("armed busy", {31'd0, ba}, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, s1[i], 0);
      if (i == 5) chk("pre valid", {31'd0, va}, 0);
    end
    chk("full valid", {31'd0, va}, 1);
    chk("full busy", {31'd0, ba}, 0);
    chk_qa("full", 5, -3, 127, -128);

    // Backpressure with samples arriving.
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 9, 0);
    chk("hold ovf", {31'd0, oa}, 1);
    chk("hold valid", {31'd0, va}, 1);
    chk_qa("hold", 5, -3, 127, -128);
    step(0, 0, 0, 0, 1);
    chk("hs valid", {31'd0, va}, 0);
    chk_qa("after hs", 5, -3, 127, -128);
    step(0, 1, 0, 0, 0);
    chk("restart ovf", {31'd0, oa}, 0);
    chk_qa("restart", 0, 0, 0, 0);

    // Gapped stream: 6 idle cycles interleaved.
    for (int j = 1; j <= 13; j++) begin
      if (j % 2 == 1) step(0, 0, 1, s1[(j-1)/2], 0);
      else step(0, 0, 0, 77, 0);
      if (j == 12) chk("gap pre valid", {31'd0, va}, 0);
    end
    chk("gap valid", {31'd0, va}, 1);
    chk_qa("gap", 5, -3, 127, -128);
    step(0, 0, 0, 0, 1);

    // No-skip instance: 1,2,3,4.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, i, 0);
      if (i == 3) chk("s0 pre valid", {31'd0, vb}, 0);
    end
    chk("s0 valid", {31'd0, vb}, 1);
    chk("s0 q0", 32'(qb[0]), 1);
    chk("s0 q3", 32'(qb[3]), 4);

    // Reset in the middle of filling.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 11 + i, 0);
    chk("mid q3", 32'(qa[3]), 15);
    step(1, 0, 0, 0, 0);
    chk("midrst busy", {31'd0, ba}, 0);
    chk("midrst valid", {31'd0, va}, 0);
    chk_qa("midrst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 7, 0);
    chk("idle en busy", {31'd0, ba}, 0);
    chk("idle en ovf", {31'd0, oa}, 0);
    chk_qa("idle en", 0, 0, 0, 0);

    // start held through collection and on the handshake.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      step(0, 1, 1, 20 + i, 0);
    chk_qa("st held", 23, 24, 25, 26);
    step(0, 1, 0, 0, 1);
    chk("st hs valid", {31'd0, va}, 0);
    chk("st hs busy", {31'd0, ba}, 0);
    step(0, 1, 0, 0, 0);
    chk("fresh busy", {31'd0, ba}, 1);
    chk_qa("fresh", 0, 0, 0, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++)
      step(($urandom % 100) == 0, ($urandom % 6) == 0,
           ($urandom % 3) != 0, int'($urandom % 256),
           ($urandom % 4) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
